// File: rtl/vh_pkg.sv
// Shared definitions for the expression-block regression drivers: bus widths,
// operand/result field map, driver state encoding and the default MISR polynomial.
package vh_pkg;

  localparam int STIM_W = 60;
  localparam int Y_W    = 90;
  localparam int SIG_W  = 32;

  // stim = {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, a0 at the MSB end
  localparam int STIM_FLD_N = 12;
  localparam int STIM_FLD_W   [STIM_FLD_N] = '{4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6};
  localparam int STIM_FLD_LSB [STIM_FLD_N] = '{56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0};

  // y = {y0..y17}, 5 bits each, y0 at the MSB end
  localparam int Y_FLD_N = 18;
  localparam int Y_FLD_W = 5;

  function automatic int y_fld_lsb(input int k);
    return Y_W - Y_FLD_W * (k + 1);
  endfunction

  localparam logic [SIG_W-1:0] DFLT_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } vh_state_e;

endpackage

// File: rtl/vh_misr.sv
// 32-bit MISR: folds a 90-bit result word to 32 bits and merges it into the
// running signature on each enabled cycle.
module vh_misr
  import vh_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = DFLT_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [Y_W-1:0]   i_y,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_fold;
  logic [SIG_W-1:0] w_shift;

  // the 26-bit top slice is zero-extended so all 90 bits reach the signature
  assign w_fold  = i_y[31:0] ^ i_y[63:32] ^ {6'b0, i_y[89:64]};
  assign w_shift = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_shift ^ w_fold;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/vh_stim_driver.sv
// Stimulus/response harness: drives LFSR operand vectors, waits for the block
// to settle, then compresses each result word into a MISR signature.
module vh_stim_driver
  import vh_pkg::*;
#(
  parameter int                SETTLE_CYC = 2,
  parameter int                CNT_W      = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY   = DFLT_POLY,
  parameter logic [63:0]       SEED_DFLT  = 64'h0123_4567_89AB_CDEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [63:0]       seed,
  output logic [STIM_W-1:0] stim,
  input  logic [Y_W-1:0]    y,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_count,
  output logic [SIG_W-1:0]  signature
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  vh_state_e         r_state, w_next;
  logic [63:0]       r_lfsr;
  logic [STIM_W-1:0] r_stim;
  logic [CNT_W-1:0]  r_vec_count;
  logic [CNT_W-1:0]  r_limit;
  logic [SC_W-1:0]   r_settle;

  logic              w_load;
  logic              w_cap;
  logic              w_settle_inc;
  logic [63:0]       w_seed;
  logic [63:0]       w_lfsr_nxt;
  logic [CNT_W-1:0]  w_vec_inc;

  assign w_seed     = (seed == 64'd0) ? SEED_DFLT : seed;
  assign w_lfsr_nxt = {r_lfsr[62:0], r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59]};
  assign w_vec_inc  = r_vec_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // abort wins over everything, including a capture due this cycle
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_cap        = 1'b0;
    w_settle_inc = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_load = 1'b1;
            w_next = (num_vec == '0) ? ST_DONE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == SC_W'(SETTLE_CYC - 1)) w_next = ST_CAPTURE;
          else                                   w_settle_inc = 1'b1;
        end
        ST_CAPTURE: begin
          w_cap  = 1'b1;
          w_next = (w_vec_inc == r_limit) ? ST_DONE : ST_SETTLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= '0;
      r_stim      <= '0;
      r_vec_count <= '0;
      r_limit     <= '0;
      r_settle    <= '0;
    end else if (w_load) begin
      r_lfsr      <= w_seed;
      r_stim      <= w_seed[STIM_W-1:0];
      r_vec_count <= '0;
      r_limit     <= num_vec;
      r_settle    <= '0;
    end else if (w_cap) begin
      r_lfsr      <= w_lfsr_nxt;
      r_stim      <= w_lfsr_nxt[STIM_W-1:0];
      r_vec_count <= w_vec_inc;
      r_settle    <= '0;
    end else if (w_settle_inc) begin
      r_settle    <= r_settle + SC_W'(1);
    end
  end

  vh_misr #(
    .POLY (SIG_POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_load),
    .i_en    (w_cap),
    .i_y     (y),
    .o_sig   (signature)
  );

  assign stim      = r_stim;
  assign vec_count = r_vec_count;
  assign busy      = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_vh_stim_driver.sv
// Bench for vh_stim_driver: a reference model queues the expected state after
// every capture and a monitor pops and compares whenever vec_count advances.
module tb_vh_stim_driver;

  localparam int          SC        = 2;
  localparam logic [63:0] SEED_DFLT = 64'h0123_4567_89AB_CDEF;
  localparam logic [31:0] POLY      = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_vec;
  logic [63:0] seed;
  logic [59:0] stim;
  logic [89:0] y;
  logic        busy;
  logic        done;
  logic [15:0] vec_count;
  logic [31:0] signature;

  int          y_mode;
  logic [31:0] y_mask;
  int          n_total = 0;
  int          n_bad   = 0;
  bit          mon_en  = 1'b0;
  logic [15:0] prev_vc = '0;

  typedef struct {
    int          cnt;
    logic [31:0] sig;
    logic [59:0] stim;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // stand-in for the expression block: a fixed function of the operands
  function automatic logic [89:0] yfun(input logic [59:0] s, input int mode, input logic [31:0] m);
    if (mode == 0) return '0;
    if (mode == 1) return '1;
    return {s[29:0], s} ^ {m[25:0], m, m};
  endfunction

  assign y = yfun(stim, y_mode, y_mask);

  vh_stim_driver dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .num_vec   (num_vec),
    .seed      (seed),
    .stim      (stim),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count),
    .signature (signature)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_lfsr(input logic [63:0] l);
    logic [63:0] taps;
    taps = 64'hD800_0000_0000_0000;  // bits 63,62,60,59
    return {l[62:0], ^(l & taps)};
  endfunction

  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [89:0] v);
    logic [31:0] fold;
    fold = v[31:0] ^ v[63:32] ^ {6'd0, v[89:64]};
    return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'd0)) ^ fold;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_vc = '0;
    end else if (vec_count != prev_vc) begin
      if (mon_en && vec_count != 0) begin
        if (sb.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL sb_underflow: got vec_count %0d expected no capture", vec_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("mon_cnt", 64'(vec_count), 64'(e.cnt));
          check("mon_sig", 64'(signature), 64'(e.sig));
          check("mon_stim", 64'(stim), 64'(e.stim));
        end
      end
      prev_vc = vec_count;
    end
  end

  task automatic run(input logic [63:0] s, input int n, input int mode,
                     input int abort_vec, input bit poke);
    logic [63:0] l;
    logic [31:0] sig;
    logic [31:0] m;
    logic [59:0] init_stim;
    int          lim;
    int          cyc;
    bit          poked;
    m      = $urandom;
    y_mask = m;
    y_mode = mode;
    l      = (s == 64'd0) ? SEED_DFLT : s;
    init_stim = l[59:0];
    sig    = '0;
    lim    = (abort_vec > 0) ? abort_vec - 1 : n;
    for (int k = 1; k <= lim; k++) begin
      sig = ref_misr(sig, yfun(l[59:0], mode, m));
      l   = ref_lfsr(l);
      sb.push_back('{k, sig, l[59:0]});
    end

    seed    = s;
    num_vec = 16'(n);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_stim", 64'(stim), 64'(init_stim));
    check("start_vc", 64'(vec_count), 64'd0);
    check("start_done", 64'(done), 64'(n == 0));
    if (n == 0) check("zero_busy", 64'(busy), 64'd0);

    cyc   = 1;
    poked = 1'b0;
    while (!done && cyc < 400) begin
      if (abort_vec > 0 && busy && vec_count == 16'(abort_vec - 1)) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_vc", 64'(vec_count), 64'(abort_vec - 1));
        check("abort_sig", 64'(signature), 64'(sig));
        @(negedge clk);
        check("abort_idle", 64'(busy | done), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();
        return;
      end
      if (poke && !poked && vec_count == 16'd10) begin
        poked = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("done_lat", 64'(cyc), 64'(n * (SC + 1) + 1));
    check("final_vc", 64'(vec_count), 64'(n));
    check("final_sig", 64'(signature), 64'(sig));
    @(negedge clk);
    check("done_hold", 64'(done), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int chg;
    logic [63:0] rs;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    num_vec = '0;
    seed    = '0;
    y_mode  = 0;
    y_mask  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stim", 64'(stim), 64'd0);
    check("rst_sig", 64'(signature), 64'd0);
    check("rst_flags", 64'({busy, done, vec_count}), 64'd0);
    chg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stim != 0 || signature != 0 || vec_count != 0 || busy || done) chg++;
    end
    check("idle_hold", 64'(chg), 64'd0);
    mon_en = 1'b1;

    run(64'h1, 3, 0, 0, 1'b0);
    check("zero_y_sig", 64'(signature), 64'd0);
    run(64'h0, 4, 2, 0, 1'b0);
    run(64'h5A5A_0000_1234_0001, 1, 1, 0, 1'b0);
    check("ones_sig", 64'(signature), 64'h03FF_FFFF);
    run(64'h77, 0, 2, 0, 1'b0);
    run(64'hDEAD_BEEF_0BAD_F00D, 100, 2, 5, 1'b0);
    run(64'h0F0F_1234_5678_9ABC, 100, 2, 0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      rs = {$urandom, $urandom};
      run(rs, $urandom_range(1, 8), 2, 0, 1'b0);
    end

    // asynchronous reset in the middle of a run
    mon_en  = 1'b0;
    seed    = 64'hABCD;
    num_vec = 16'd50;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_stim", 64'(stim), 64'd0);
    check("arst_sig", 64'(signature), 64'd0);
    check("arst_flags", 64'({busy, done, vec_count}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle", 64'({busy, done, vec_count}), 64'd0);
    mon_en = 1'b1;
    run(64'h3, 2, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
